hex_keypad_entry: RTL
=====================

// Module: hex_keypad_entry
// PURPOSE
//  Scans a 4x4 hex matrix keypad, debounces presses and encodes each key to a nibble.
//  Shifts each new nibble into an 8-bit entry register: new digit enters on the right, old right digit moves left.
//  The register and blank flag drive the dual seven-segment display's data/blank inputs.
//  This block is the input-side writer for that display.
// PARAMETERS
//  SCAN_DIV         default 1000  clk cycles per column dwell; legal range >= 4
//  DEBOUNCE_CYCLES  default 50000 consecutive stable cycles to accept a press or a release
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  rows       in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  cols       out  4  keypad column drive, active-low, exactly one bit low at a time
//  data       out  8  entered byte: [7:4] previous digit, [3:0] newest digit
//  key_code   out  4  code of the last accepted key
//  key_valid  out  1  one-cycle pulse per accepted key
//  blank      out  1  high until the first key is accepted (blanks the display)
// BEHAVIOUR
//  Reset values: cols=4'b1110, data=8'h00, key_code=4'h0, key_valid=0, blank=1.
//  Reset also sets FSM=SCAN and all counters to 0. Reset mid-operation aborts silently (no pulse).
//  rows always passes a 2-flop synchronizer (rs); all decisions below use rs.
//  Key map (row r, col c, c=0 leftmost):
//    r0: 1 2 3 A
//    r1: 4 5 6 B
//    r2: 7 8 9 C
//    r3: E 0 F D
//  FSM:
//   SCAN: the active column is held for SCAN_DIV cycles, then the next column is driven (col3 wraps to col0).
//     Rows are sampled on the last dwell cycle.
//     If rs has exactly one bit low: latch the row and column, go to DEBOUNCE with the column held.
//     If rs has zero or several bits low: no key; keep scanning.
//   DEBOUNCE: counts cycles while rs equals the latched pattern.
//     Any mismatch: counter cleared, return to SCAN at the same column.
//     Count reaches DEBOUNCE_CYCLES: go to PRESSED.
//   PRESSED (1 cycle): key_code<=map, data<={data[3:0],map}, blank<=0, key_valid<=1.
//     These outputs are registered and become visible together on the next cycle.
//     Then go to RELEASE.
//   RELEASE: column still held. Requires rs==4'hF for DEBOUNCE_CYCLES consecutive cycles.
//     Any low bit restarts the count.
//     When the count completes: go to SCAN at col0.
//  A held key yields exactly one pulse. No auto-repeat.
//  Other keys pressed while in RELEASE are ignored until full release.
//  Press-to-pulse latency <= 4*SCAN_DIV + DEBOUNCE_CYCLES + 4 cycles.
//  Counter widths use $clog2 of their parameter. Counters saturate, never wrap.
// CONFIGURATION
//  KEYPAD_CLEAR_EN defined:
//    Key r3/c0 is the clear key: data<=8'h00, blank<=1, key_code<=4'hE, key_valid pulses.
//  KEYPAD_CLEAR_EN undefined:
//    Key r3/c0 enters 4'hE like any other digit.
// STRUCTURE
//  Package keypad_pkg:
//    - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
//    - KEY_MAP[4][4] constant table
//    - CLEAR_KEY row/col constants
//  Sub-module keypad_sync: 4-bit 2-flop synchronizer with async reset to 4'hF.
//  Top level holds the FSM, the dwell and debounce counters, and the output registers.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//  1. Reset asserted mid-DEBOUNCE of key 7:
//     -> cols=1110, data=00, blank=1, key_valid=0, and no pulse follows.
//  2. Hold r1/c1 stable for 200 cycles:
//     -> exactly one key_valid, key_code=5, data=05, blank=0.
//  3. Press and release 3, then A:
//     -> data 03 then 3A. Then press 5 -> data A5.
//  4. Hold r2/c2 with 9 bouncing (toggle every 3 cycles for 30 cycles), then stable:
//     -> one pulse, code 9. Bounce on release gives no extra pulse.
//  5. Drive r0 and r1 low together on c2:
//     -> no key_valid for 500 cycles, and data unchanged.
//  6. After data=5A, press r3/c0 with KEYPAD_CLEAR_EN:
//     -> data=00, blank=1, code E.
//     Same press without the macro -> data=AE.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the hex keypad entry block:
//                FSM state encoding, key map table, clear-key location and
//                small row-pattern helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Indexed [row][col], col 0 is the leftmost column.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    localparam logic [1:0] CLEAR_ROW = 2'd3;
    localparam logic [1:0] CLEAR_COL = 2'd0;

    // True when exactly one active-low row line is asserted.
    function automatic logic single_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Index of the (single) low bit of an active-low row pattern.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_sync
//  Description : 4-bit two-flop synchronizer for the keypad row lines.
//                Resets to all-ones (idle, no key pressed).
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_async,
    output logic [3:0] o_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // Two back-to-back flops to resolve metastability on the row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/hex_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : hex_keypad_entry
//  Description : Scans a 4x4 active-low hex keypad, debounces press and
//                release, encodes the key and shifts it into an 8-bit entry
//                register feeding a dual seven-segment display.
//                Optional macro KEYPAD_CLEAR_EN turns key r3/c0 into a clear
//                key (entry zeroed, display blanked).
//  Revision    : 1.0  initial release
// ============================================================================
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] data,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       blank
);

    localparam int DW = (SCAN_DIV > 1)        ? $clog2(SCAN_DIV)        : 1;
    localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] C_DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] C_DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_col,   w_col_nxt;
    logic [DW-1:0] r_dwell, w_dwell_nxt;
    logic [BW-1:0] r_deb,   w_deb_nxt;
    logic [1:0]    r_row,   w_row_nxt;
    logic [3:0]    r_pat,   w_pat_nxt;
    logic [7:0]    r_data,  w_data_nxt;
    logic [3:0]    r_code,  w_code_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_blank, w_blank_nxt;
    logic [3:0]    w_rs;
    logic [3:0]    w_key;

    keypad_sync u_sync (
        .clk     (clk),
        .rst     (reset),
        .i_async (rows),
        .o_sync  (w_rs)
    );

    assign w_key = KEY_MAP[r_row][r_col];

    // State, counters and output registers; everything returns to idle on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SCAN;
            r_col   <= 2'd0;
            r_dwell <= '0;
            r_deb   <= '0;
            r_row   <= 2'd0;
            r_pat   <= 4'hF;
            r_data  <= 8'h00;
            r_code  <= 4'h0;
            r_valid <= 1'b0;
            r_blank <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_dwell <= w_dwell_nxt;
            r_deb   <= w_deb_nxt;
            r_row   <= w_row_nxt;
            r_pat   <= w_pat_nxt;
            r_data  <= w_data_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_blank <= w_blank_nxt;
        end
    end

    // Next-state and next-register logic. Counters only increment below their
    // terminal value, so they can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_dwell_nxt = r_dwell;
        w_deb_nxt   = r_deb;
        w_row_nxt   = r_row;
        w_pat_nxt   = r_pat;
        w_data_nxt  = r_data;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_blank_nxt = r_blank;

        case (r_state)
            SCAN: begin
                if (r_dwell >= C_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (single_low(w_rs)) begin
                        // Exactly one row low: hold this column and debounce.
                        w_pat_nxt   = w_rs;
                        w_row_nxt   = low_index(w_rs);
                        w_deb_nxt   = '0;
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (w_rs == r_pat) begin
                    if (r_deb >= C_DEB_LAST) begin
                        w_deb_nxt   = '0;
                        w_state_nxt = PRESSED;
                    end else begin
                        w_deb_nxt = r_deb + 1'b1;
                    end
                end else begin
                    // Bounce or a different pattern: rescan this same column.
                    w_deb_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_state_nxt = SCAN;
                end
            end

            PRESSED: begin
                w_valid_nxt = 1'b1;
                w_deb_nxt   = '0;
                w_state_nxt = RELEASE;
`ifdef KEYPAD_CLEAR_EN
                if ((r_row == CLEAR_ROW) && (r_col == CLEAR_COL)) begin
                    w_data_nxt  = 8'h00;
                    w_blank_nxt = 1'b1;
                    w_code_nxt  = 4'hE;
                end else begin
                    w_data_nxt  = {r_data[3:0], w_key};
                    w_blank_nxt = 1'b0;
                    w_code_nxt  = w_key;
                end
`else
                w_data_nxt  = {r_data[3:0], w_key};
                w_blank_nxt = 1'b0;
                w_code_nxt  = w_key;
`endif
            end

            RELEASE: begin
                if (w_rs == 4'hF) begin
                    if (r_deb >= C_DEB_LAST) begin
                        // Fully released: restart scanning from the left column.
                        w_deb_nxt   = '0;
                        w_dwell_nxt = '0;
                        w_col_nxt   = 2'd0;
                        w_state_nxt = SCAN;
                    end else begin
                        w_deb_nxt = r_deb + 1'b1;
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = SCAN;
            end
        endcase
    end

    assign cols      = ~(4'b0001 << r_col);
    assign data      = r_data;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign blank     = r_blank;

endmodule
`default_nettype wire
